// File: rtl/sha1_pkg.sv
// Shared types and constants for the bit-serial SHA-1 control sequencer.
package sha1_pkg;

    localparam int unsigned WORDS_H     = 5;
    localparam int unsigned WORD_BITS   = 32;
    localparam int unsigned ROUNDS      = 80;
    localparam int unsigned SCHED_START = 16;
    localparam int unsigned ROUND_GRP   = ROUNDS / 4;

    localparam int unsigned STEP_W = $clog2(WORD_BITS);
    localparam int unsigned WORD_W = $clog2(WORDS_H);
    localparam int unsigned IDX_W  = $clog2(ROUNDS);
    localparam int unsigned GRP_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        COPY,
        ROUND,
        FINAL
    } state_e;

    localparam logic [1:0] F_CH  = 2'd0;
    localparam logic [1:0] F_PAR = 2'd1;
    localparam logic [1:0] F_MAJ = 2'd2;

    // Round group 0..3, each ROUND_GRP rounds long.
    function automatic logic [GRP_W-1:0] round_grp(input logic [IDX_W-1:0] r);
        if (r < IDX_W'(ROUND_GRP))          return GRP_W'(0);
        else if (r < IDX_W'(2 * ROUND_GRP)) return GRP_W'(1);
        else if (r < IDX_W'(3 * ROUND_GRP)) return GRP_W'(2);
        else                                return GRP_W'(3);
    endfunction

endpackage

// File: rtl/sha1_bitctr.sv
// Bit-step / word-or-round counter with wrap flags; idx wraps to 0 at idx_last.
module sha1_bitctr
    import sha1_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    input  logic [IDX_W-1:0]  idx_last,
    output logic [STEP_W-1:0] step_q,
    output logic [IDX_W-1:0]  idx_q,
    output logic              step_wrap,
    output logic              idx_wrap
);

    assign step_wrap = (step_q == STEP_W'(WORD_BITS - 1));
    assign idx_wrap  = (idx_q == idx_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= '0;
            idx_q  <= '0;
        end else if (clr) begin
            step_q <= '0;
            idx_q  <= '0;
        end else if (adv) begin
            if (step_wrap) begin
                step_q <= '0;
                idx_q  <= idx_wrap ? '0 : idx_q + IDX_W'(1);
            end else begin
                step_q <= step_q + STEP_W'(1);
            end
        end
    end

endmodule

// File: rtl/sha1_seq.sv
// SHA-1 block sequencer: INIT/COPY -> 80 ROUNDs -> FINAL, one bit per advancing cycle.
// Optional abort input enabled by defining SHA1_SEQ_ABORT_EN.
module sha1_seq
    import sha1_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               first_block,
    input  logic               stall,
`ifdef SHA1_SEQ_ABORT_EN
    input  logic               abort,
`endif
    output logic [WORDS_H-1:0] init_sel,
    output logic [3:0]         round_sel,
    output logic [STEP_W-1:0]  step,
    output logic [WORD_W-1:0]  word,
    output logic [IDX_W-1:0]   round,
    output logic [1:0]         f_sel,
    output logic               init_en,
    output logic               copy_en,
    output logic               round_en,
    output logic               final_en,
    output logic               sched_en,
    output logic               word_last,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic               adv, clr, done_d, done_q;
    logic               phase_last, step_wrap, idx_wrap;
    logic [STEP_W-1:0]  step_q;
    logic [IDX_W-1:0]   idx_q, idx_last;
    logic [GRP_W-1:0]   grp;

    assign idx_last   = (state_q == ROUND) ? IDX_W'(ROUNDS - 1) : IDX_W'(WORDS_H - 1);
    assign phase_last = step_wrap && idx_wrap;

    sha1_bitctr u_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .adv      (adv),
        .idx_last (idx_last),
        .step_q   (step_q),
        .idx_q    (idx_q),
        .step_wrap(step_wrap),
        .idx_wrap (idx_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next state; counters only advance in an active, unstalled cycle.
    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        clr     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = first_block ? INIT : COPY;
            end
            INIT, COPY: begin
                adv = !stall;
                if (adv && phase_last) state_d = ROUND;
            end
            ROUND: begin
                adv = !stall;
                if (adv && phase_last) state_d = FINAL;
            end
            FINAL: begin
                adv = !stall;
                if (adv && phase_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef SHA1_SEQ_ABORT_EN
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            adv     = 1'b0;
            clr     = 1'b1;
            done_d  = 1'b0;
        end
`endif
    end

    assign grp = round_grp(idx_q);

    always_comb begin
        busy      = (state_q != IDLE);
        step      = busy ? step_q : '0;
        word      = '0;
        round     = '0;
        init_sel  = '0;
        round_sel = '0;
        f_sel     = F_CH;
        case (state_q)
            INIT: begin
                word     = WORD_W'(idx_q);
                init_sel = WORDS_H'(1) << idx_q;
            end
            COPY, FINAL: word = WORD_W'(idx_q);
            ROUND: begin
                round     = idx_q;
                round_sel = 4'b1000 >> grp;
                case (grp)
                    2'd0:    f_sel = F_CH;
                    2'd1:    f_sel = F_PAR;
                    2'd2:    f_sel = F_MAJ;
                    default: f_sel = F_PAR | F_MAJ;
                endcase
            end
            default: ;
        endcase
        init_en   = (state_q == INIT)  && adv;
        copy_en   = (state_q == COPY)  && adv;
        round_en  = (state_q == ROUND) && adv;
        final_en  = (state_q == FINAL) && adv;
        sched_en  = round_en && (idx_q >= IDX_W'(SCHED_START));
        word_last = busy && step_wrap;
        done      = done_q;
    end

endmodule

// File: tb/tb_sha1_seq.sv
// Directed bench for sha1_seq; define SHA1_SEQ_ABORT_EN to also exercise abort.
module tb_sha1_seq;

    logic       clk = 1'b0;
    logic       rst, start, first_block, stall;
`ifdef SHA1_SEQ_ABORT_EN
    logic       abort;
`endif
    logic [4:0] init_sel;
    logic [3:0] round_sel;
    logic [4:0] step;
    logic [2:0] word;
    logic [6:0] round;
    logic [1:0] f_sel;
    logic       init_en, copy_en, round_en, final_en, sched_en, word_last, busy, done;
    logic [33:0] all_out;

    int n_vec = 0;
    int n_err = 0;

    int cnt_init, cnt_copy, cnt_round, cnt_final;
    int first_sched, first_done, n_done, n_overlap, n_step_bad, n_isel;

    sha1_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_block(first_block),
        .stall      (stall),
`ifdef SHA1_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .init_sel   (init_sel),
        .round_sel  (round_sel),
        .step       (step),
        .word       (word),
        .round      (round),
        .f_sel      (f_sel),
        .init_en    (init_en),
        .copy_en    (copy_en),
        .round_en   (round_en),
        .final_en   (final_en),
        .sched_en   (sched_en),
        .word_last  (word_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign all_out = {init_sel, round_sel, step, word, round, f_sel, init_en, copy_en,
                      round_en, final_en, sched_en, word_last, busy, done};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One block from start; cycle 0 is the first INIT/COPY cycle.
    task automatic run_block(input logic fb, input int stall_c, input int stall_n, input bit pulses);
        cnt_init = 0; cnt_copy = 0; cnt_round = 0; cnt_final = 0;
        first_sched = -1; first_done = -1; n_done = 0; n_overlap = 0;
        n_step_bad = 0; n_isel = 0;
        start = 1'b1; first_block = fb;
        @(posedge clk); #1;
        start = 1'b0; first_block = 1'b0;
        for (int c = 0; c < 2890; c++) begin
            stall = (c >= stall_c) && (c < stall_c + stall_n);
            start = pulses && (c == 100 || c == 2000);
            #1;
            if (init_en)  cnt_init++;
            if (copy_en)  cnt_copy++;
            if (round_en) cnt_round++;
            if (final_en) cnt_final++;
            if (init_sel != 5'd0) n_isel++;
            if (sched_en && first_sched < 0) first_sched = c;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c;
                if (init_en | copy_en | round_en | final_en | sched_en) n_overlap++;
            end
            if (stall_n == 0 && c < 2880 && step != 5'(c % 32)) n_step_bad++;
            if (fb && stall_n == 0) begin
                if (c < 160 && c % 32 == 0)
                    check("init_sel", 64'(init_sel), 64'(1) << (c / 32));
                case (c)
                    0:    check("c0",    64'({init_en, word, step, busy}), 64'({1'b1, 3'd0, 5'd0, 1'b1}));
                    31:   check("c31",   64'({word_last, word}), 64'({1'b1, 3'd0}));
                    159:  check("c159",  64'({init_en, word, step}), 64'({1'b1, 3'd4, 5'd31}));
                    160:  check("c160",  64'({round_sel, f_sel, round, init_sel, init_en, round_en}),
                                         64'({4'b1000, 2'd0, 7'd0, 5'd0, 1'b0, 1'b1}));
                    800:  check("c800",  64'({round_sel, f_sel, round}), 64'({4'b0100, 2'd1, 7'd20}));
                    1440: check("c1440", 64'({round_sel, f_sel, round}), 64'({4'b0010, 2'd2, 7'd40}));
                    2080: check("c2080", 64'({round_sel, f_sel, round}), 64'({4'b0001, 2'd3, 7'd60}));
                    2720: check("c2720", 64'({final_en, word, round, round_sel}), 64'({1'b1, 3'd0, 7'd0, 4'd0}));
                    2879: check("c2879", 64'({final_en, word, step, word_last}), 64'({1'b1, 3'd4, 5'd31, 1'b1}));
                    2880: check("c2880", 64'({done, busy, final_en}), 64'({1'b1, 1'b0, 1'b0}));
                    2881: check("c2881", 64'(all_out), 64'd0);
                    default: ;
                endcase
            end
            if (stall_n != 0) begin
                if (c >= stall_c && c < stall_c + stall_n)
                    check("stall_hold", 64'({round, step, round_sel, round_en, final_en, sched_en}),
                          64'({7'd79, 5'd31, 4'b0001, 1'b0, 1'b0, 1'b0}));
                if (c == stall_c + stall_n)
                    check("stall_rel", 64'({round, step, round_en}), 64'({7'd79, 5'd31, 1'b1}));
                if (c == stall_c + stall_n + 1)
                    check("stall_final", 64'({final_en, word, step}), 64'({1'b1, 3'd0, 5'd0}));
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; first_block = 1'b0; stall = 1'b0;
`ifdef SHA1_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        check("reset_outs", 64'(all_out), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("idle_outs", 64'(all_out), 64'd0);

        // Asynchronous reset in the middle of ROUND.
        start = 1'b1; first_block = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; first_block = 1'b0;
        for (int i = 0; i < 1356; i++) begin
            @(posedge clk); #1;
        end
        check("pre_rst", 64'({round, step, busy, round_en}), 64'({7'd37, 5'd12, 1'b1, 1'b1}));
        #2 rst = 1'b1;
        #1;
        check("async_rst", 64'(all_out), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Full block from ROM constants.
        run_block(1'b1, -10, 0, 1'b0);
        check("init_cnt",   64'(cnt_init),    64'd160);
        check("round_cnt",  64'(cnt_round),   64'd2560);
        check("final_cnt",  64'(cnt_final),   64'd160);
        check("sched_1st",  64'(first_sched), 64'd672);
        check("done_at",    64'(first_done),  64'd2880);
        check("done_cnt",   64'(n_done),      64'd1);
        check("done_excl",  64'(n_overlap),   64'd0);
        check("step_seq",   64'(n_step_bad),  64'd0);

        // Chained block with ignored start pulses while busy.
        run_block(1'b0, -10, 0, 1'b1);
        check("copy_cnt",   64'(cnt_copy),    64'd160);
        check("copy_noini", 64'({cnt_init, n_isel}), 64'd0);
        check("copy_done",  64'(first_done),  64'd2880);
        check("copy_dcnt",  64'(n_done),      64'd1);
        check("copy_step",  64'(n_step_bad),  64'd0);
        check("copy_rnd",   64'(cnt_round),   64'd2560);

        // Stall 3 cycles on the final ROUND bit.
        run_block(1'b1, 2719, 3, 1'b0);
        check("stl_done",   64'(first_done),  64'd2883);
        check("stl_dcnt",   64'(n_done),      64'd1);
        check("stl_rnd",    64'(cnt_round),   64'd2560);
        check("stl_fin",    64'(cnt_final),   64'd160);
        check("stl_excl",   64'(n_overlap),   64'd0);

        // start and stall together in IDLE: start accepted, first cycle stalled.
        start = 1'b1; first_block = 1'b1; stall = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; first_block = 1'b0;
        check("st_stl0", 64'({busy, init_en, init_sel, step}), 64'({1'b1, 1'b0, 5'b00001, 5'd0}));
        stall = 1'b0;
        #1;
        check("st_stl1", 64'({init_en, step}), 64'({1'b1, 5'd0}));
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

`ifdef SHA1_SEQ_ABORT_EN
        start = 1'b1; first_block = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; first_block = 1'b0;
        for (int i = 0; i < 2784; i++) begin
            @(posedge clk); #1;
        end
        check("pre_abort", 64'({final_en, word, step}), 64'({1'b1, 3'd2, 5'd0}));
        abort = 1'b1; stall = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; stall = 1'b0;
        check("abort_idle", 64'(all_out), 64'd0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) n_done++;
            @(posedge clk); #1;
        end
        check("abort_nodone", 64'(n_done), 64'd0);
        abort = 1'b1; start = 1'b1; first_block = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0; first_block = 1'b0;
        check("abort_start", 64'({busy, init_en, init_sel, step}), 64'({1'b1, 1'b1, 5'b00001, 5'd0}));
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_clr", 64'(all_out), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
